memory_access_stage: RTL and testbench
======================================

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, giving the maximum WAIT cycles before an access is aborted (legal range 1..255).
REQ-002 SHALL have a single clock and reset, both listed first: clk_i  input  1  rising-edge clock; reset_i  input  1  asynchronous, active-high reset.
REQ-003 SHALL take the upstream execute/memory register outputs:
- em_reg_write_i  in  1  register write enable.
- em_mem_read_i  in  1  load.
- em_mem_write_i  in  1  store.
- em_dmem_to_reg_i  in  2  writeback source: 00 ALU, 01 memory, 10 PC+4, 11 ALU.
- em_write_addr_reg_i  in  5  destination register.
- em_alu_result_i  in  32  ALU result / effective address.
- em_read_data2_i  in  32  store data.
- em_pcsrc_i  in  32  PC+4.
- em_funct3_i  in  3  access size and sign.
REQ-004 SHALL provide the data-memory port:
- dmem_req_o  out  1
- dmem_we_o  out  1
- dmem_addr_o  out  32
- dmem_wdata_o  out  32
- dmem_be_o  out  4
- dmem_ack_i  in  1
- dmem_rdata_i  in  32
REQ-005 SHALL provide mem_stall_o  out  1, which holds the upstream stages while high.
REQ-006 SHALL provide registered memory/writeback outputs:
- mw_reg_write_o  out  1
- mw_write_addr_reg_o  out  5
- mw_wb_data_o  out  32
- mw_bus_err_o  out  1
- mw_misalign_o  out  1

Function
REQ-007 SHALL define an access as em_mem_read_i|em_mem_write_i; if both are high, the store takes priority.
REQ-008 SHALL implement the state machine IDLE/WAIT:
- IDLE with access: dmem_req_o=1 combinationally.
- ack in the same cycle: the access completes with no stall.
- otherwise: mem_stall_o=1 and the next state is WAIT.
REQ-009 In WAIT, SHALL hold dmem_req_o=1 and all dmem_* fields constant, with mem_stall_o=~dmem_ack_i; on ack, SHALL complete and return to IDLE.
REQ-010 SHALL count WAIT cycles in a cycle counter that clears on entering WAIT; when the count reaches TIMEOUT_CYCLES without an ack, SHALL:
- complete with mw_reg_write_o=0 and mw_bus_err_o=1 for one cycle;
- deassert dmem_req_o and mem_stall_o that cycle;
- return to IDLE.
REQ-011 SHALL ignore dmem_ack_i whenever dmem_req_o=0.
REQ-012 SHALL drive dmem_addr_o={em_alu_result_i[31:2],2'b00} and dmem_we_o=em_mem_write_i.
REQ-013 Store byte enables (a=em_alu_result_i[1:0]):
- SB: dmem_be_o=4'b0001<<a, with wdata holding the low byte replicated ×4.
- SH: dmem_be_o=4'b0011<<{a[1],0}, with the low half replicated ×2.
- SW: dmem_be_o=4'b1111.
- Loads: dmem_be_o=4'b1111.
REQ-014 Load data SHALL be dmem_rdata_i shifted right by 8*a (halfword: by 16*a[1]), then extended:
- LB/LH: sign-extended.
- LBU/LHU: zero-extended.
- LW: unchanged.
- Other funct3 values: treated as LW.
REQ-015 mw_wb_data_o SHALL be selected by em_dmem_to_reg_i: formatted load data, em_alu_result_i, or em_pcsrc_i.
REQ-016 MEM/WB outputs SHALL update on every rising edge where mem_stall_o=0; the instruction is captured with a latency of 1 cycle after completion.
REQ-017 While mem_stall_o=1, each rising edge SHALL load a bubble: mw_reg_write_o=0, mw_bus_err_o=0, mw_misalign_o=0, with address/data unchanged.
REQ-018 A non-access instruction SHALL pass in one cycle with mem_stall_o=0 and dmem_req_o=0.
REQ-019 Writes to x0 SHALL pass unchanged; suppressing them is not this block's job.

Reset
REQ-020 reset_i high SHALL immediately force:
- state=IDLE, counter=0;
- all mw_* outputs to 0;
- dmem_req_o=0 and mem_stall_o=0, regardless of inputs.
REQ-021 An access in flight at reset SHALL be abandoned; a late dmem_ack_i after reset is ignored per REQ-011.

Configuration
REQ-022 SHALL honour macro DMEM_MISALIGN_CHECK_EN.
- Defined: a halfword with a[0]=1, or a word with a!=0, SHALL:
  - issue no dmem request;
  - complete in one cycle with mw_reg_write_o=0 and mw_misalign_o=1.
- Undefined: the low address bits are ignored per REQ-012..014 and mw_misalign_o is tied to 0.

Verification
REQ-023 Zero-wait LW: addr 0x100, ack same cycle, rdata 0xDEADBEEF, rd=5 -> stall never high; next edge mw_wb_data_o=0xDEADBEEF, mw_write_addr_reg_o=5, mw_reg_write_o=1.
REQ-024 Wait-state LB: addr 0x103, ack after 3 cycles, rdata 0x80000000 -> stall high 3 cycles with bubbles, then mw_wb_data_o=0xFFFFFF80; LBU at the same address gives 0x00000080.
REQ-025 SH of 0x1234 at 0x202 -> dmem_be_o=4'b1100, dmem_wdata_o=0x12341234, dmem_addr_o=0x200, dmem_we_o=1.
REQ-026 No ack with TIMEOUT_CYCLES=15 -> stall for 15 cycles, then mw_bus_err_o=1 for one cycle, mw_reg_write_o=0, dmem_req_o drops.
REQ-027 Reset asserted mid-WAIT -> outputs 0 asynchronously; a subsequent ack causes no writeback.
REQ-028 With DMEM_MISALIGN_CHECK_EN defined, LW at 0x101 -> no dmem_req_o, mw_misalign_o=1, mw_reg_write_o=0; without it, the same access reads 0x100.

Source files
------------

// File: rtl/memory_access_stage.sv
// Memory stage of a 5-stage pipeline. It drives a request/ack data-memory port with a wait-state timeout, and formats loads and stores.
// Optional macro DMEM_MISALIGN_CHECK_EN: traps misaligned halfword/word accesses instead of issuing them.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        em_reg_write_i,
  input  logic        em_mem_read_i,
  input  logic        em_mem_write_i,
  input  logic [1:0]  em_dmem_to_reg_i,
  input  logic [4:0]  em_write_addr_reg_i,
  input  logic [31:0] em_alu_result_i,
  input  logic [31:0] em_read_data2_i,
  input  logic [31:0] em_pcsrc_i,
  input  logic [2:0]  em_funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        mem_stall_o,
  output logic        mw_reg_write_o,
  output logic [4:0]  mw_write_addr_reg_o,
  output logic [31:0] mw_wb_data_o,
  output logic        mw_bus_err_o,
  output logic        mw_misalign_o
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mw_reg_write_q, mw_reg_write_d;
  logic [4:0]  mw_write_addr_reg_q, mw_write_addr_reg_d;
  logic [31:0] mw_wb_data_q, mw_wb_data_d;
  logic        mw_bus_err_q, mw_bus_err_d;
  logic        mw_misalign_q, mw_misalign_d;

  logic [1:0]  byte_off;
  logic        access, misalign, acc_ok, timeout;
  logic [31:0] byte_sh, half_sh, load_data, wb_sel;

  assign byte_off = em_alu_result_i[1:0];
  assign access   = em_mem_read_i | em_mem_write_i;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = access &&
                    ((em_funct3_i[1:0] == 2'b01 && byte_off[0]) ||
                     (em_funct3_i[1:0] == 2'b10 && byte_off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_ok = access & ~misalign;

  // Port fields are combinational from the EX/MEM inputs, which the stall freezes during WAIT.
  assign dmem_addr_o = {em_alu_result_i[31:2], 2'b00};
  assign dmem_we_o   = em_mem_write_i;

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = em_read_data2_i;
    if (em_mem_write_i) begin
      case (em_funct3_i[1:0])
        2'b00: begin
          dmem_be_o    = 4'b0001 << byte_off;
          dmem_wdata_o = {4{em_read_data2_i[7:0]}};
        end
        2'b01: begin
          dmem_be_o    = 4'b0011 << {byte_off[1], 1'b0};
          dmem_wdata_o = {2{em_read_data2_i[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = em_read_data2_i;
        end
      endcase
    end
  end

  always_comb begin
    byte_sh = dmem_rdata_i >> {byte_off, 3'b000};
    half_sh = dmem_rdata_i >> {byte_off[1], 4'b0000};
    case (em_funct3_i)
      3'b000:  load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  load_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100:  load_data = {24'h0, byte_sh[7:0]};
      3'b101:  load_data = {16'h0, half_sh[15:0]};
      default: load_data = dmem_rdata_i;
    endcase
    case (em_dmem_to_reg_i)
      2'b01:   wb_sel = load_data;
      2'b10:   wb_sel = em_pcsrc_i;
      default: wb_sel = em_alu_result_i;
    endcase
  end

  // The timeout cycle drops the request, so an ack arriving then is never seen.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dmem_req_o  = 1'b0;
    mem_stall_o = 1'b0;
    timeout     = 1'b0;
    if (!reset_i) begin
      case (state_q)
        IDLE: begin
          if (acc_ok) begin
            dmem_req_o = 1'b1;
            if (!dmem_ack_i) begin
              mem_stall_o = 1'b1;
              state_d     = WAIT;
              cnt_d       = 8'd0;
            end
          end
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            timeout = 1'b1;
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            dmem_req_o = 1'b1;
            if (dmem_ack_i) begin
              state_d = IDLE;
              cnt_d   = 8'd0;
            end else begin
              mem_stall_o = 1'b1;
              cnt_d       = cnt_q + 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mw_reg_write_d      = 1'b0;
    mw_write_addr_reg_d = mw_write_addr_reg_q;
    mw_wb_data_d        = mw_wb_data_q;
    mw_bus_err_d        = 1'b0;
    mw_misalign_d       = 1'b0;
    if (!mem_stall_o) begin
      mw_reg_write_d      = em_reg_write_i & ~timeout & ~misalign;
      mw_write_addr_reg_d = em_write_addr_reg_i;
      mw_wb_data_d        = wb_sel;
      mw_bus_err_d        = timeout;
      mw_misalign_d       = misalign;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q             <= IDLE;
      cnt_q               <= 8'd0;
      mw_reg_write_q      <= 1'b0;
      mw_write_addr_reg_q <= 5'd0;
      mw_wb_data_q        <= 32'd0;
      mw_bus_err_q        <= 1'b0;
      mw_misalign_q       <= 1'b0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      mw_reg_write_q      <= mw_reg_write_d;
      mw_write_addr_reg_q <= mw_write_addr_reg_d;
      mw_wb_data_q        <= mw_wb_data_d;
      mw_bus_err_q        <= mw_bus_err_d;
      mw_misalign_q       <= mw_misalign_d;
    end
  end

  assign mw_reg_write_o      = mw_reg_write_q;
  assign mw_write_addr_reg_o = mw_write_addr_reg_q;
  assign mw_wb_data_o        = mw_wb_data_q;
  assign mw_bus_err_o        = mw_bus_err_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign mw_misalign_o       = mw_misalign_q;
`else
  assign mw_misalign_o       = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: stimulus pushes expected writebacks, a negedge monitor pops and compares them.
module tb_memory_access_stage;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        em_reg_write_i, em_mem_read_i, em_mem_write_i;
  logic [1:0]  em_dmem_to_reg_i;
  logic [4:0]  em_write_addr_reg_i;
  logic [31:0] em_alu_result_i, em_read_data2_i, em_pcsrc_i;
  logic [2:0]  em_funct3_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        mem_stall_o;
  logic        mw_reg_write_o;
  logic [4:0]  mw_write_addr_reg_o;
  logic [31:0] mw_wb_data_o;
  logic        mw_bus_err_o, mw_misalign_o;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        mis;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  memory_access_stage #(.TIMEOUT_CYCLES(15)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .em_reg_write_i(em_reg_write_i), .em_mem_read_i(em_mem_read_i),
    .em_mem_write_i(em_mem_write_i), .em_dmem_to_reg_i(em_dmem_to_reg_i),
    .em_write_addr_reg_i(em_write_addr_reg_i), .em_alu_result_i(em_alu_result_i),
    .em_read_data2_i(em_read_data2_i), .em_pcsrc_i(em_pcsrc_i),
    .em_funct3_i(em_funct3_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .mem_stall_o(mem_stall_o),
    .mw_reg_write_o(mw_reg_write_o), .mw_write_addr_reg_o(mw_write_addr_reg_o),
    .mw_wb_data_o(mw_wb_data_o), .mw_bus_err_o(mw_bus_err_o),
    .mw_misalign_o(mw_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic push(input logic rw, input logic [4:0] rd, input logic [31:0] data,
                      input logic err, input logic mis, input string nm);
    exp_t x;
    x.rw = rw; x.rd = rd; x.data = data; x.err = err; x.mis = mis; x.nm = nm;
    sb_q.push_back(x);
  endtask

  task automatic drive(input logic rw, input logic mr, input logic mw, input logic [1:0] d2r,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc);
    em_reg_write_i = rw; em_mem_read_i = mr; em_mem_write_i = mw;
    em_dmem_to_reg_i = d2r; em_funct3_i = f3; em_write_addr_reg_i = rd;
    em_alu_result_i = alu; em_read_data2_i = wd; em_pcsrc_i = pc;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Runs an already-driven access; the ack arrives 'waits' cycles after the request.
  task automatic access(input string nm, input int waits, input logic [31:0] rdata);
    for (int i = 0; i <= waits; i++) begin
      dmem_ack_i   = (i == waits);
      dmem_rdata_i = (i == waits) ? rdata : 32'h0BAD0BAD;
      #2;
      chk($sformatf("%s_req_c%0d", nm, i), 32'(dmem_req_o), 32'd1);
      chk($sformatf("%s_stall_c%0d", nm, i), 32'(mem_stall_o), 32'(i != waits));
      cyc();
    end
    dmem_ack_i = 1'b0;
  endtask

  task automatic passthru(input string nm, input logic [1:0] d2r, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] exp);
    drive(1'b1, 1'b0, 1'b0, d2r, 3'b010, rd, alu, 32'h0, pc);
    dmem_ack_i = 1'b0;
    #2;
    chk({nm, "_req"}, 32'(dmem_req_o), 32'd0);
    chk({nm, "_stall"}, 32'(mem_stall_o), 32'd0);
    push(1'b1, rd, exp, 1'b0, 1'b0, nm);
    cyc();
  endtask

  always @(negedge clk_i) begin
    if (!reset_i && (mw_reg_write_o || mw_bus_err_o || mw_misalign_o)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_wb: got rw=%0b rd=%0d data=%h err=%0b mis=%0b, expected none",
                 mw_reg_write_o, mw_write_addr_reg_o, mw_wb_data_o, mw_bus_err_o, mw_misalign_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk({mon_e.nm, "_wb_rw"}, 32'(mw_reg_write_o), 32'(mon_e.rw));
        chk({mon_e.nm, "_wb_err"}, 32'(mw_bus_err_o), 32'(mon_e.err));
        chk({mon_e.nm, "_wb_mis"}, 32'(mw_misalign_o), 32'(mon_e.mis));
        if (mon_e.rw) begin
          chk({mon_e.nm, "_wb_rd"}, 32'(mw_write_addr_reg_o), 32'(mon_e.rd));
          chk({mon_e.nm, "_wb_data"}, mw_wb_data_o, mon_e.data);
        end
      end
    end
  end

  initial begin
    dmem_ack_i = 1'b0;
    dmem_rdata_i = 32'h0;
    // An access presented during reset must not produce a request or stall.
    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd4, 32'h100, 32'h0, 32'h0);
    #1 reset_i = 1'b1;
    #2;
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_stall", 32'(mem_stall_o), 32'd0);
    chk("rst_rw", 32'(mw_reg_write_o), 32'd0);
    chk("rst_rd", 32'(mw_write_addr_reg_o), 32'd0);
    chk("rst_data", mw_wb_data_o, 32'd0);
    chk("rst_err", 32'(mw_bus_err_o), 32'd0);
    @(posedge clk_i);
    cyc();
    reset_i = 1'b0;

    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd5, 32'h100, 32'h0, 32'h0);
    #1;
    chk("lw_addr", dmem_addr_o, 32'h100);
    chk("lw_be", 32'(dmem_be_o), 32'hF);
    chk("lw_we", 32'(dmem_we_o), 32'd0);
    #0 push(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, "lw0");
    access("lw0", 0, 32'hDEADBEEF);

    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b000, 5'd6, 32'h103, 32'h0, 32'h0);
    push(1'b1, 5'd6, 32'hFFFFFF80, 1'b0, 1'b0, "lb3");
    access("lb3", 3, 32'h80000000);

    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b100, 5'd6, 32'h103, 32'h0, 32'h0);
    push(1'b1, 5'd6, 32'h00000080, 1'b0, 1'b0, "lbu");
    access("lbu", 0, 32'h80000000);

    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b001, 5'd11, 32'h102, 32'h0, 32'h0);
    push(1'b1, 5'd11, 32'hFFFF8001, 1'b0, 1'b0, "lh");
    access("lh", 1, 32'h80017FFF);

    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b101, 5'd12, 32'h100, 32'h0, 32'h0);
    push(1'b1, 5'd12, 32'h00007FFF, 1'b0, 1'b0, "lhu");
    access("lhu", 0, 32'h80017FFF);

    drive(1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 5'd0, 32'h202, 32'h00001234, 32'h0);
    #1;
    chk("sh_be", 32'(dmem_be_o), 32'hC);
    chk("sh_wdata", dmem_wdata_o, 32'h12341234);
    chk("sh_addr", dmem_addr_o, 32'h200);
    chk("sh_we", 32'(dmem_we_o), 32'd1);
    access("sh", 0, 32'h0);

    drive(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'd0, 32'h201, 32'h000000AB, 32'h0);
    #1;
    chk("sb_be", 32'(dmem_be_o), 32'h2);
    chk("sb_wdata", dmem_wdata_o, 32'hABABABAB);
    access("sb", 2, 32'h0);

    drive(1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 5'd0, 32'h300, 32'hCAFEF00D, 32'h0);
    #1;
    chk("sw_be", 32'(dmem_be_o), 32'hF);
    chk("sw_wdata", dmem_wdata_o, 32'hCAFEF00D);
    chk("sw_rdwr_we", 32'(dmem_we_o), 32'd1);
    access("sw", 0, 32'h0);

    passthru("alu", 2'b00, 5'd7, 32'h55, 32'h1000, 32'h55);
    passthru("pc4", 2'b10, 5'd1, 32'h66, 32'h1004, 32'h1004);
    passthru("alu11", 2'b11, 5'd2, 32'h77, 32'h1008, 32'h77);
    passthru("x0", 2'b00, 5'd0, 32'h99, 32'h100C, 32'h99);

    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd8, 32'h101, 32'h0, 32'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
    dmem_ack_i = 1'b0;
    #2;
    chk("mis_req", 32'(dmem_req_o), 32'd0);
    chk("mis_stall", 32'(mem_stall_o), 32'd0);
    push(1'b0, 5'd8, 32'h0, 1'b0, 1'b1, "mis");
    cyc();
`else
    #1;
    chk("mis_addr", dmem_addr_o, 32'h100);
    push(1'b1, 5'd8, 32'h11223344, 1'b0, 1'b0, "mis");
    access("mis", 0, 32'h11223344);
`endif

    // No ack: 15 stalled cycles, then a single bus-error completion with the request dropped.
    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd9, 32'h400, 32'h0, 32'h0);
    dmem_ack_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #2;
      chk($sformatf("tmo_stall_c%0d", i), 32'(mem_stall_o), 32'd1);
      chk($sformatf("tmo_req_c%0d", i), 32'(dmem_req_o), 32'd1);
      cyc();
    end
    #2;
    chk("tmo_end_stall", 32'(mem_stall_o), 32'd0);
    chk("tmo_end_req", 32'(dmem_req_o), 32'd0);
    push(1'b0, 5'd9, 32'h0, 1'b1, 1'b0, "tmo");
    cyc();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 5'd0, 32'h0, 32'h0, 32'h0);
    cyc();

    // Reset in the middle of a WAIT, then a late ack that must not write back.
    passthru("pre_rst", 2'b00, 5'd7, 32'h55, 32'h0, 32'h55);
    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd10, 32'h500, 32'h0, 32'h0);
    dmem_ack_i = 1'b0;
    cyc();
    #1;
    chk("rw_wait_stall", 32'(mem_stall_o), 32'd1);
    #1 reset_i = 1'b1;
    #1;
    chk("rw_rst_req", 32'(dmem_req_o), 32'd0);
    chk("rw_rst_stall", 32'(mem_stall_o), 32'd0);
    chk("rw_rst_rd", 32'(mw_write_addr_reg_o), 32'd0);
    chk("rw_rst_data", mw_wb_data_o, 32'd0);
    cyc();
    reset_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 5'd10, 32'h500, 32'h0, 32'h0);
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'h12345678;
    #2;
    chk("late_ack_req", 32'(dmem_req_o), 32'd0);
    chk("late_ack_stall", 32'(mem_stall_o), 32'd0);
    cyc();
    cyc();
    dmem_ack_i = 1'b0;

    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd3, 32'h104, 32'h0, 32'h0);
    push(1'b1, 5'd3, 32'h00001111, 1'b0, 1'b0, "post_rst_lw");
    access("post_rst_lw", 0, 32'h00001111);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 5'd0, 32'h0, 32'h0, 32'h0);
    repeat (3) cyc();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
